// File: rtl/fc_argmax_pkg.sv
// Shared widths and the running/result argmax payload for the fc_argmax classifier stage.
package fc_argmax_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = $clog2(N);

    typedef struct packed {
        logic signed [WIDTH-1:0] val;
        logic [IDX_W-1:0]        idx;
        logic                    tie;
    } argmax_t;

endpackage

// File: rtl/fc_argmax_if.sv
// Element stream in and per-frame argmax result out, both valid/ready.
interface fc_argmax_if;
    import fc_argmax_pkg::*;

    logic                    input_valid;
    logic                    input_ready;
    logic signed [WIDTH-1:0] input_data;
    logic                    output_valid;
    logic                    output_ready;
    logic [IDX_W-1:0]        output_index;
    logic signed [WIDTH-1:0] output_max;
    logic                    output_tie;

    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_index, output_max, output_tie
    );

    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_index, output_max, output_tie
    );

endinterface

// File: rtl/fc_argmax_cmp.sv
// Folds one element into the running argmax; the lowest index wins on equal values.
module fc_argmax_cmp
    import fc_argmax_pkg::*;
(
    input  argmax_t                 run,
    input  logic signed [WIDTH-1:0] elem,
    input  logic [IDX_W-1:0]        pos,
    input  logic                    first,
    output argmax_t                 cand
);

    always_comb begin
        cand = run;
        if (first) begin
            cand.val = elem;
            cand.idx = '0;
            cand.tie = 1'b0;
        end else if (elem > $signed(run.val)) begin
            cand.val = elem;
            cand.idx = pos;
            cand.tie = 1'b0;
        end else if (elem == $signed(run.val)) begin
            cand.tie = 1'b1;
        end
    end

endmodule

// File: rtl/fc_argmax.sv
// Streaming argmax over N-element frames from the final FC layer, one result per frame.
module fc_argmax
    import fc_argmax_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    fc_argmax_if.slave bus
);

    logic [IDX_W-1:0] elem_cnt;
    argmax_t          run_q;
    argmax_t          out_q;
    argmax_t          cand;
    logic             out_valid_q;
    logic             last_elem;
    logic             first_elem;
    logic             accept;
    logic             drain;

    assign last_elem  = (elem_cnt == IDX_W'(N - 1));
    assign first_elem = (elem_cnt == '0);

    // Only the closing element waits for a pending result; it may drain on the same edge.
    assign bus.input_ready = !(last_elem && out_valid_q && !bus.output_ready);
    assign accept          = bus.input_valid && bus.input_ready;
    assign drain           = out_valid_q && bus.output_ready;

    fc_argmax_cmp u_cmp (
        .run   (run_q),
        .elem  (bus.input_data),
        .pos   (elem_cnt),
        .first (first_elem),
        .cand  (cand)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_cnt    <= '0;
            run_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (drain) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (last_elem) begin
                    out_q       <= cand;
                    out_valid_q <= 1'b1;
                    elem_cnt    <= '0;
                end else begin
                    run_q    <= cand;
                    elem_cnt <= elem_cnt + IDX_W'(1);
                end
            end
        end
    end

    assign bus.output_valid = out_valid_q;
    assign bus.output_index = out_q.idx;
    assign bus.output_max   = out_q.val;
    assign bus.output_tie   = out_q.tie;

endmodule
